pdm_mod16: RTL and testbench

Second-order sigma-delta PDM modulator: accepts signed 16-bit PCM samples over a valid/ready handshake and emits a 1-bit PDM stream plus its bit clock, emulating a PDM microphone. It is the transmit end of the microphone link. It drives the array's PDM decimation chain for closed-loop bench and on-board self-test, and it also feeds PDM-input peripherals.

---
 rtl/pdm_mod16.sv | 180 ++++++++++++++++++
 tb/tb_pdm_mod16.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mod16.sv
// pdm_mod16: second-order sigma-delta PDM modulator emulating a PDM microphone.
// Signed 16-bit PCM samples arrive over valid/ready into a one-deep buffer; each
// OSR-bit frame consumes one sample and emits a 1-bit stream with its bit clock.
module pdm_mod16 #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned OSR     = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic signed [15:0] pcm_in,
    input  logic               pcm_valid,
    output logic               pcm_ready,
    output logic               pdm_clk,
    output logic               pdm_out,
    output logic               underrun
);

    localparam int unsigned PCM_W = 16;
    localparam int unsigned ACC_W = 24;
    // Integrator sums need two guard bits above the 24-bit state before clamping.
    localparam int unsigned SUM_W = ACC_W + 2;
    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (OSR > 1) ? $clog2(OSR) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FALL = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(OSR - 1);

    localparam logic signed [SUM_W-1:0] FB_POS  = SUM_W'(32768);
    localparam logic signed [SUM_W-1:0] FB_NEG  = SUM_W'(-32768);
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(8388607);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-8388608);

    // Clamp a guarded sum into the 24-bit integrator range so it never wraps.
    function automatic logic signed [ACC_W-1:0] sat24(input logic signed [SUM_W-1:0] v);
        if (v > SAT_MAX) begin
            return ACC_W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return ACC_W'(SAT_MIN);
        end else begin
            return ACC_W'(v);
        end
    endfunction

    // Registered state
    logic [CNT_W-1:0]         r_cnt;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic signed [ACC_W-1:0]  r_i1;
    logic signed [ACC_W-1:0]  r_i2;
    logic signed [PCM_W-1:0]  r_active;
    logic signed [PCM_W-1:0]  r_buf;
    logic                     r_full;
    logic                     r_pcm_ready;
    logic                     r_pdm_clk;
    logic                     r_pdm_out;
    logic                     r_underrun;

    // Combinational helpers
    logic                     w_hs;
    logic                     w_tick;
    logic                     w_fall;
    logic                     w_frame_start;
    logic                     w_load;
    logic                     w_full_next;
    logic signed [PCM_W-1:0]  w_x;
    logic signed [SUM_W-1:0]  w_fb;
    logic signed [SUM_W-1:0]  w_sum1;
    logic signed [SUM_W-1:0]  w_sum2;
    logic signed [ACC_W-1:0]  w_i1_next;
    logic signed [ACC_W-1:0]  w_i2_next;

    // Handshake, divider events and frame boundary decode
    assign w_hs          = pcm_valid && r_pcm_ready;
    assign w_tick        = en && (r_cnt == CNT_LAST);
    assign w_fall        = en && (r_cnt == CNT_FALL);
    assign w_frame_start = w_tick && (r_bit_cnt == '0);
    assign w_load        = w_frame_start && r_full;

    // A handshake only happens with the buffer empty, so it never collides with a load.
    assign w_full_next   = w_hs ? 1'b1 : (w_load ? 1'b0 : r_full);

    // Modulator datapath: the sample loaded at this tick is used immediately.
    assign w_x       = w_load ? r_buf : r_active;
    assign w_fb      = r_pdm_out ? FB_POS : FB_NEG;
    assign w_sum1    = SUM_W'(r_i1) + SUM_W'(w_x) - w_fb;
    assign w_i1_next = sat24(w_sum1);
    assign w_sum2    = SUM_W'(r_i2) + SUM_W'(w_i1_next) - w_fb;
    assign w_i2_next = sat24(w_sum2);

    // One-deep holding buffer; ready mirrors the next empty state so it is registered yet exact.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_buf       <= '0;
            r_full      <= 1'b0;
            r_pcm_ready <= 1'b0;
        end else begin
            if (w_hs) begin
                r_buf <= pcm_in;
            end
            r_full      <= w_full_next;
            r_pcm_ready <= !w_full_next;
        end
    end

    // Active sample: taken from the buffer at a frame start, otherwise held (also while disabled).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= '0;
        end else if (w_load) begin
            r_active <= r_buf;
        end
    end

    // Bit-clock divider: high from the tick edge for CLK_DIV/2 cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_pdm_clk <= 1'b0;
        end else if (!en) begin
            r_cnt     <= '0;
            r_pdm_clk <= 1'b0;
        end else begin
            if (w_tick) begin
                r_cnt     <= '0;
                r_pdm_clk <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_fall) begin
                    r_pdm_clk <= 1'b0;
                end
            end
        end
    end

    // Frame position within the OSR-bit frame, advanced once per tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
        end else if (!en) begin
            r_bit_cnt <= '0;
        end else if (w_tick) begin
            r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : (r_bit_cnt + BIT_W'(1));
        end
    end

    // Integrators and output bit, updated on every tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i1      <= '0;
            r_i2      <= '0;
            r_pdm_out <= 1'b0;
        end else if (!en) begin
            r_i1      <= '0;
            r_i2      <= '0;
            r_pdm_out <= 1'b0;
        end else if (w_tick) begin
            r_i1      <= w_i1_next;
            r_i2      <= w_i2_next;
            r_pdm_out <= (w_i2_next >= 0);
        end
    end

    // Sticky underrun: a frame started with nothing in the buffer; cleared by disable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_underrun <= 1'b0;
        end else if (!en) begin
            r_underrun <= 1'b0;
        end else if (w_frame_start && !r_full) begin
            r_underrun <= 1'b1;
        end
    end

    assign pcm_ready = r_pcm_ready;
    assign pdm_clk   = r_pdm_clk;
    assign pdm_out   = r_pdm_out;
    assign underrun  = r_underrun;

endmodule

// File: tb/tb_pdm_mod16.sv
// tb_pdm_mod16: self-checking bench for pdm_mod16 with a cycle reference model,
// an expected-bit queue, a density vector table and hand-written corner sequences.
module tb_pdm_mod16;

    localparam int CLK_DIV = 4;
    localparam int OSR     = 32;

    logic               clk       = 1'b0;
    logic               rst_n     = 1'b0;
    logic               en        = 1'b0;
    logic               pcm_valid = 1'b0;
    logic signed [15:0] pcm_in    = '0;
    logic               pcm_ready;
    logic               pdm_clk;
    logic               pdm_out;
    logic               underrun;

    pdm_mod16 #(.CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pdm_clk   (pdm_clk),
        .pdm_out   (pdm_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // ---------------- reference model (evaluated on negedge for the preceding posedge)
    int s_rst = 0, s_en = 0, s_valid = 0, s_pcm = 0;
    int m_cnt = 0, m_bc = 0, m_i1 = 0, m_i2 = 0, m_out = 0, m_pclk = 0;
    int m_und = 0, m_full = 0, m_ready = 0, m_buf = 0, m_act = 0;
    int fs_cnt = 0;
    int exp_q[$];

    function automatic int clamp24(input int v);
        if (v > 8388607)  return 8388607;
        if (v < -8388608) return -8388608;
        return v;
    endfunction

    task automatic model_step();
        int hs;
        int fb;
        if (s_rst == 0) begin
            m_cnt = 0; m_bc = 0; m_i1 = 0; m_i2 = 0; m_out = 0; m_pclk = 0;
            m_und = 0; m_full = 0; m_ready = 0; m_buf = 0; m_act = 0;
            exp_q.delete();
            return;
        end
        hs = (s_valid != 0 && m_ready != 0) ? 1 : 0;
        if (s_en == 0) begin
            m_cnt = 0; m_bc = 0; m_i1 = 0; m_i2 = 0; m_out = 0; m_pclk = 0; m_und = 0;
        end else if (m_cnt == CLK_DIV - 1) begin
            m_cnt  = 0;
            m_pclk = 1;
            if (m_bc == 0) begin
                fs_cnt++;
                if (m_full != 0) begin
                    m_act  = m_buf;
                    m_full = 0;
                end else begin
                    m_und = 1;
                end
            end
            fb    = (m_out != 0) ? 32768 : -32768;
            m_i1  = clamp24(m_i1 + m_act - fb);
            m_i2  = clamp24(m_i2 + m_i1 - fb);
            m_out = (m_i2 >= 0) ? 1 : 0;
            exp_q.push_back(m_out);
            m_bc = (m_bc + 1) % OSR;
        end else begin
            if (m_cnt == CLK_DIV / 2 - 1) m_pclk = 0;
            m_cnt++;
        end
        if (hs != 0) begin
            m_buf  = s_pcm;
            m_full = 1;
        end
        m_ready = (m_full != 0) ? 0 : 1;
    endtask

    // ---------------- monitor / scoreboard
    int prev_pclk = 0, tick_cnt = 0, acc_cnt = 0;
    int counting = 0, logging = 0, ones = 0, bits = 0;
    int last_rise = 0, period = 0, high_run = 0, high_time = 0;
    int got_q[$];

    // Advance the model, compare control outputs every cycle and data bits at each bit-clock rise.
    always @(negedge clk) begin
        int e;
        cyc++;
        model_step();
        check("pcm_ready", int'(pcm_ready), m_ready);
        check("pdm_clk", int'(pdm_clk), m_pclk);
        check("underrun", int'(underrun), m_und);
        if (pdm_clk && prev_pclk == 0) begin
            tick_cnt++;
            if (exp_q.size() == 0) begin
                check("pdm_tick_expected", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("pdm_out", int'(pdm_out), e);
            end
            if (counting != 0) begin
                bits++;
                ones += int'(pdm_out);
            end
            if (logging != 0) got_q.push_back(int'(pdm_out));
            period    = cyc - last_rise;
            last_rise = cyc;
            high_run  = 1;
        end else if (pdm_clk) begin
            high_run++;
        end else if (prev_pclk != 0) begin
            high_time = high_run;
        end
        if (pcm_valid && pcm_ready && rst_n) acc_cnt++;
        prev_pclk = int'(pdm_clk);
        s_rst   = int'(rst_n);
        s_en    = int'(en);
        s_valid = int'(pcm_valid);
        s_pcm   = int'(pcm_in);
    end

    // ---------------- stimulus helpers
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ticks(input int n, input string name);
        int t0;
        int c;
        t0 = tick_cnt;
        c  = 0;
        while ((tick_cnt - t0) < n && c < n * CLK_DIV + 64) begin
            step(1);
            c++;
        end
        if ((tick_cnt - t0) < n) check(name, tick_cnt - t0, n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; pcm_valid = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    typedef struct {
        logic signed [15:0] pcm;
        int                 nbits;
        int                 lo;
        int                 hi;
        int                 first7;
    } vec_t;

    vec_t vecs[3];
    int   exp7[7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int a0;
        int f0;
        int last_acc;
        int c;
        logic signed [15:0] nxt;

        vecs[0] = '{pcm: 16'sd0,      nbits: 1024, lo: 508,  hi: 516,  first7: 1};
        vecs[1] = '{pcm: 16'sd16384,  nbits: 4096, lo: 3032, hi: 3112, first7: 0};
        vecs[2] = '{pcm: -16'sd16384, nbits: 4096, lo: 984,  hi: 1064, first7: 0};
        exp7 = '{1, 1, 0, 1, 0, 0, 1};

        // Reset state and release
        step(3);
        check("rst_pcm_ready", int'(pcm_ready), 0);
        check("rst_pdm_clk", int'(pdm_clk), 0);
        check("rst_pdm_out", int'(pdm_out), 0);
        check("rst_underrun", int'(underrun), 0);
        rst_n = 1'b1;
        step(1);
        check("rst_release_ready", int'(pcm_ready), 1);

        // Constant-input density table
        for (int k = 0; k < 3; k++) begin
            do_reset();
            got_q.delete();
            ones = 0; bits = 0; counting = 1; logging = 1;
            pcm_in = vecs[k].pcm; pcm_valid = 1'b1; en = 1'b1;
            wait_ticks(vecs[k].nbits, "density_wait");
            counting = 0; logging = 0;
            check($sformatf("bits_counted_%0d", k), bits, vecs[k].nbits);
            check_range($sformatf("ones_density_%0d", int'(vecs[k].pcm)), ones, vecs[k].lo, vecs[k].hi);
            if (vecs[k].first7 != 0 && got_q.size() >= 7) begin
                for (int i = 0; i < 7; i++) check($sformatf("zero_bit_%0d", i), got_q[i], exp7[i]);
                check("pdm_clk_period", period, CLK_DIV);
                check("pdm_clk_high", high_time, CLK_DIV / 2);
            end
        end

        // Full scale: negative then positive, integrators must saturate rather than wrap
        do_reset();
        pcm_in = -16'sd32768; pcm_valid = 1'b1; en = 1'b1;
        ones = 0; bits = 0; counting = 1;
        wait_ticks(64 * OSR, "fs_neg_wait");
        counting = 0;
        check_range("fullscale_neg_ones", ones, 0, 4);
        pcm_in = 16'sh7FFF;
        wait_ticks(3 * OSR, "fs_settle_wait");
        ones = 0; bits = 0; counting = 1;
        wait_ticks(64 * OSR, "fs_pos_wait");
        counting = 0;
        check_range("fullscale_pos_ones", ones, 2044, 2048);

        // Handshake with pcm_valid held high
        do_reset();
        f0 = fs_cnt; a0 = acc_cnt;
        pcm_in = 16'sh1000; pcm_valid = 1'b1;
        step(1);
        check("hs_first_accept", acc_cnt - a0, 1);
        check("hs_ready_low", int'(pcm_ready), 0);
        pcm_in = 16'sh2000; en = 1'b1;
        n = 0;
        while (!pcm_ready && n < 3 * CLK_DIV) begin
            step(1);
            n++;
        end
        check("hs_ready_rise_latency", n, CLK_DIV);
        step(1);
        check("hs_second_accept", acc_cnt - a0, 2);
        check("hs_ready_low_again", int'(pcm_ready), 0);
        nxt = 16'sh3000; pcm_in = nxt; last_acc = acc_cnt; c = 0;
        while ((fs_cnt - f0) < 8 && c < 8 * OSR * CLK_DIV + 64) begin
            step(1);
            c++;
            if (acc_cnt != last_acc) begin
                last_acc = acc_cnt;
                nxt = nxt + 16'sh1000;
                pcm_in = nxt;
            end
        end
        step(2);
        check("hs_no_loss_dup", acc_cnt - a0, fs_cnt - f0 + 1);
        check("hs_no_underrun", int'(underrun), 0);

        // Underrun, disable and re-enable
        pcm_valid = 1'b0;
        f0 = fs_cnt; c = 0;
        while ((fs_cnt - f0) < 2 && c < 2 * OSR * CLK_DIV + 64) begin
            step(1);
            c++;
        end
        step(1);
        check("underrun_set", int'(underrun), 1);
        en = 1'b0;
        step(5);
        check("dis_underrun", int'(underrun), 0);
        check("dis_pdm_clk", int'(pdm_clk), 0);
        check("dis_pdm_out", int'(pdm_out), 0);
        check("dis_pcm_ready", int'(pcm_ready), 1);
        en = 1'b1;
        n = 0;
        while (!pdm_clk && n < 4 * CLK_DIV) begin
            step(1);
            n++;
        end
        check("reen_first_tick", n, CLK_DIV);
        check("reen_frame_start", int'(underrun), 1);

        // Reset in the middle of a frame
        pcm_in = 16'sh0800; pcm_valid = 1'b1;
        step(50);
        rst_n = 1'b0;
        step(3);
        check("mid_rst_pdm_clk", int'(pdm_clk), 0);
        check("mid_rst_pdm_out", int'(pdm_out), 0);
        check("mid_rst_underrun", int'(underrun), 0);
        check("mid_rst_pcm_ready", int'(pcm_ready), 0);
        rst_n = 1'b1;
        step(1);
        check("mid_rst_release_ready", int'(pcm_ready), 1);
        n = 0;
        while (!pdm_clk && n < 4 * CLK_DIV) begin
            step(1);
            n++;
        end
        check("mid_rst_first_tick", n, CLK_DIV - 1);
        check("mid_rst_frame_load", int'(pcm_ready), 1);
        check("mid_rst_no_underrun", int'(underrun), 0);
        step(10);
        pcm_valid = 1'b0;
        step(5);
        check("scoreboard_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
